fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the decode-stage forwarding unit.
- Resolves operand sources for NUM_RS read ports against NUM_STAGES in-order pipeline stages.
- Adds a registered scoreboard for long-latency writers (divider, miss-handling loads) that complete out of pipeline order, including a same-cycle completion bypass and WAW protection.
- Sits beside decode; drives the decode operand muxes and the decode stall.

Parameters:
- NUM_RS, 2, number of source-register read ports checked per decode instruction
- NUM_STAGES, 3, number of forwarding pipeline stages; index 0 is youngest (execute)
- NUM_LL, 2, maximum outstanding long-latency writes tracked
- REG_W, 5, register index width (32 architectural registers)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- de_valid  in  1  decode holds a valid instruction
- de_rs  in  NUM_RS*REG_W  source registers; port i is bits [i*REG_W +: REG_W]
- de_rd  in  REG_W  decode destination register, used for the WAW check
- de_rd_en  in  1  decode instruction writes de_rd
- st_fwd_valid  in  NUM_STAGES  stage s holds a valid register write
- st_fwd_stall  in  NUM_STAGES  stage s result is not yet available
- st_wb_reg  in  NUM_STAGES*REG_W  stage s destination register
- ll_issue_valid  in  1  long-latency op is issuing this cycle
- ll_issue_reg  in  REG_W  destination of the issuing long-latency op
- ll_issue_ready  out  1  scoreboard can accept the issue
- ll_done_valid  in  1  long-latency result is written back this cycle
- ll_done_reg  in  REG_W  destination of the completing op
- flush  in  1  pipeline flush; long-latency unit aborts all in-flight ops
- fwd_sel  out  NUM_RS*(NUM_STAGES+1)  one-hot per port: bit s selects stage s; bit NUM_STAGES selects the ll_done bypass; all zero selects the register file
- fwd_stall  out  1  decode must stall
- sb_busy  out  32  scoreboard busy vector (debug/visibility)

Behaviour:
- Reset (synchronous, reset_n low at a clk edge):
  - busy vector and occupancy count clear to 0.
  - Outputs after reset: sb_busy=0, ll_issue_ready=1; fwd_sel and fwd_stall are combinational from inputs, so with de_valid=0 they are 0.
  - Reset asserted mid-operation drops all entries with no completion required.
- Per-port source resolution (combinational), for port i with register r = de_rs[i]:
  - r==0: sel=0, no stall.
  - Otherwise, take the lowest stage s with st_fwd_valid[s] and st_wb_reg[s]==r: sel bit s, stall = st_fwd_stall[s].
  - Else if ll_done_valid and ll_done_reg==r: sel bit NUM_STAGES, no stall.
  - Else if busy[r]: sel=0, stall.
  - Else: sel=0 (register file), no stall.
- WAW stall: de_valid & de_rd_en & de_rd!=0 & busy[de_rd] & !(ll_done_valid & ll_done_reg==de_rd).
- fwd_stall = de_valid & (OR of port stalls | WAW stall). When de_valid=0, fwd_sel=0 and fwd_stall=0.
- Scoreboard update (registered):
  - done: clears busy[ll_done_reg] and decrements count.
  - issue (ll_issue_valid & ll_issue_ready & ll_issue_reg!=0): sets busy[ll_issue_reg] and increments count.
  - Same cycle, same register: set wins; count is net unchanged.
  - ll_issue_reg==0: accepted, allocates nothing.
  - ll_done on a non-busy register: ignored, count unchanged. Simulation assertion fires.
- ll_issue_ready = (count<NUM_LL or ll_done_valid) & (!busy[ll_issue_reg] or (ll_done_valid & ll_done_reg==ll_issue_reg)).
- flush: next state is busy=0, count=0, overriding any same-cycle issue or done. Combinational outputs in the flush cycle are computed normally.
- Count width: $clog2(NUM_LL+1). It never exceeds NUM_LL (assertion).

Optional Feature:
- Macro: FWD_SCOREBOARD_PERF_EN.
- With the macro defined, two 32-bit output counters are added:
  - perf_hazard_cnt increments each cycle fwd_stall is caused only by stage stalls.
  - perf_sb_cnt increments each cycle fwd_stall involves a scoreboard or WAW stall.
  - Both reset to 0 and saturate at all-ones.
- Without the macro, the ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Shared package: REG_W default, fwd_src_e encoding (REGFILE/STAGE/LL_BYPASS), a stall-cause typedef, and a helper function giving the fwd_sel width.
- One sub-module: fwd_port_select, the per-port priority resolver, instantiated NUM_RS times via generate.
- Scoreboard flops and counters stay in the top module.

Test Plan:
- Reset then idle: sb_busy=0, ll_issue_ready=1, fwd_stall=0 with de_valid=0.
- de_rs={x5,x5}; stage0 and stage2 both write x5, st_fwd_stall=0 -> fwd_sel port0=port1=4'b0001, fwd_stall=0. Then set st_fwd_stall[0]=1 -> fwd_stall=1.
- Issue ll to x7; next cycle decode reads x7 -> fwd_stall=1, sel=0. Assert ll_done x7 -> same cycle sel bit3, stall=0; next cycle busy[7]=0.
- NUM_LL=2: issue x3 and x4 -> ll_issue_ready=0 for x9. Same cycle ll_done x3 -> ready=1; issue x9 accepted; count stays 2.
- WAW: busy[x6]=1, decode de_rd=x6 with no sources -> fwd_stall=1. Issuing x6 again -> ready=0.
- Flush with busy={x3,x4} plus a simultaneous issue of x8 -> next cycle sb_busy=0, count=0. Reset asserted mid-operation gives the same result.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared types and helpers for the forwarding scoreboard
package fwd_scoreboard_pkg;

  // Architectural register index width (32 registers)
  localparam int REG_W_DEF = 5;

  // Where a source operand is taken from
  typedef enum logic [1:0] {
    SRC_REGFILE   = 2'd0,
    SRC_STAGE     = 2'd1,
    SRC_LL_BYPASS = 2'd2
  } fwd_src_e;

  // Why a read port wants decode to stall
  typedef struct packed {
    logic stage;  // matching pipeline stage has no result yet
    logic sb;     // long-latency write still outstanding
  } stall_cause_t;

  // Total width of the one-hot select bus: per port, one bit per stage plus the bypass
  function automatic int fwd_sel_width(input int num_rs, input int num_stages);
    return num_rs * (num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_port_select.sv
// rtl/fwd_port_select.sv - priority resolver for one decode read port
module fwd_port_select
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic [REG_W-1:0]            i_rs,
  input  logic [NUM_STAGES-1:0]       i_st_valid,
  input  logic [NUM_STAGES-1:0]       i_st_stall,
  input  logic [NUM_STAGES*REG_W-1:0] i_st_reg,
  input  logic                        i_ll_done_valid,
  input  logic [REG_W-1:0]            i_ll_done_reg,
  input  logic [(1<<REG_W)-1:0]       i_busy,
  output logic [NUM_STAGES:0]         o_sel,
  output stall_cause_t                o_cause
);

  logic [NUM_STAGES-1:0] w_match;
  logic [NUM_STAGES-1:0] w_stage_oh;
  fwd_src_e              w_src;

  // compare every stage's destination against this port's source register
  always_comb begin
    w_match = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_match[s] = i_st_valid[s] && (i_st_reg[s*REG_W +: REG_W] == i_rs);
    end
  end

  // youngest (lowest-index) matching stage wins
  assign w_stage_oh = w_match & (~w_match + NUM_STAGES'(1));

  // priority: x0, then pipeline stages, then completion bypass, then register file
  always_comb begin
    w_src = SRC_REGFILE;
    if (i_rs != '0) begin
      if (|w_match) begin
        w_src = SRC_STAGE;
      end else if (i_ll_done_valid && (i_ll_done_reg == i_rs)) begin
        w_src = SRC_LL_BYPASS;
      end
    end
  end

  assign o_sel = {(w_src == SRC_LL_BYPASS),
                  (w_src == SRC_STAGE) ? w_stage_oh : {NUM_STAGES{1'b0}}};

  assign o_cause.stage = (w_src == SRC_STAGE) && (|(w_stage_oh & i_st_stall));
  assign o_cause.sb    = (i_rs != '0) && (w_src == SRC_REGFILE) && i_busy[i_rs];

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - decode forwarding unit with long-latency scoreboard (optional perf counters: FWD_SCOREBOARD_PERF_EN)
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_RS     = 2,
  parameter int NUM_STAGES = 3,
  parameter int NUM_LL     = 2,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             de_valid,
  input  logic [NUM_RS*REG_W-1:0]                          de_rs,
  input  logic [REG_W-1:0]                                 de_rd,
  input  logic                                             de_rd_en,
  input  logic [NUM_STAGES-1:0]                            st_fwd_valid,
  input  logic [NUM_STAGES-1:0]                            st_fwd_stall,
  input  logic [NUM_STAGES*REG_W-1:0]                      st_wb_reg,
  input  logic                                             ll_issue_valid,
  input  logic [REG_W-1:0]                                 ll_issue_reg,
  output logic                                             ll_issue_ready,
  input  logic                                             ll_done_valid,
  input  logic [REG_W-1:0]                                 ll_done_reg,
  input  logic                                             flush,
  output logic [fwd_sel_width(NUM_RS, NUM_STAGES)-1:0]     fwd_sel,
  output logic                                             fwd_stall,
  output logic [(1<<REG_W)-1:0]                            sb_busy,
  output logic [31:0]                                      perf_hazard_cnt,
  output logic [31:0]                                      perf_sb_cnt
);

  localparam int NREG  = 1 << REG_W;
  localparam int CNT_W = $clog2(NUM_LL + 1);
  localparam int SEL_W = fwd_sel_width(NUM_RS, NUM_STAGES);
  localparam logic [CNT_W-1:0] LL_MAX = CNT_W'(NUM_LL);

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_done_hit;
  logic              w_issue_acc;
  logic              w_waw;
  logic              w_stall_stage;
  logic              w_stall_sb;
  logic [SEL_W-1:0]  w_sel;
  logic [NUM_RS-1:0] w_port_stage;
  logic [NUM_RS-1:0] w_port_sb;
  stall_cause_t      w_cause [NUM_RS];

  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_port
    fwd_port_select #(
      .NUM_STAGES (NUM_STAGES),
      .REG_W      (REG_W)
    ) u_port (
      .i_rs            (de_rs[gi*REG_W +: REG_W]),
      .i_st_valid      (st_fwd_valid),
      .i_st_stall      (st_fwd_stall),
      .i_st_reg        (st_wb_reg),
      .i_ll_done_valid (ll_done_valid),
      .i_ll_done_reg   (ll_done_reg),
      .i_busy          (r_busy),
      .o_sel           (w_sel[gi*(NUM_STAGES+1) +: (NUM_STAGES+1)]),
      .o_cause         (w_cause[gi])
    );
    assign w_port_stage[gi] = w_cause[gi].stage;
    assign w_port_sb[gi]    = w_cause[gi].sb;
  end

  // a completing write to de_rd this cycle frees the register in time for decode
  assign w_waw = de_valid && de_rd_en && (de_rd != '0) && r_busy[de_rd] &&
                 !(ll_done_valid && (ll_done_reg == de_rd));

  assign w_stall_stage = |w_port_stage;
  assign w_stall_sb    = (|w_port_sb) || w_waw;
  assign fwd_stall     = de_valid && (w_stall_stage || w_stall_sb);
  assign fwd_sel       = de_valid ? w_sel : '0;

  // a done in the same cycle frees a slot and may free the very register being issued
  assign ll_issue_ready = ((r_count < LL_MAX) || ll_done_valid) &&
                          (!r_busy[ll_issue_reg] || (ll_done_valid && (ll_done_reg == ll_issue_reg)));

  assign w_done_hit  = ll_done_valid && r_busy[ll_done_reg];
  assign w_issue_acc = ll_issue_valid && ll_issue_ready && (ll_issue_reg != '0);

  // clear on done, then set on issue so a same-register issue wins; flush drops everything
  always_comb begin
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    if (w_done_hit) begin
      w_busy_nxt[ll_done_reg] = 1'b0;
      w_count_nxt             = w_count_nxt - CNT_W'(1);
    end
    if (w_issue_acc) begin
      w_busy_nxt[ll_issue_reg] = 1'b1;
      w_count_nxt              = w_count_nxt + CNT_W'(1);
    end
    if (flush) begin
      w_busy_nxt  = '0;
      w_count_nxt = '0;
    end
  end

  // scoreboard state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign sb_busy = r_busy;

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] r_perf_hazard;
  logic [31:0] r_perf_sb;

  // saturating stall-cause counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_hazard <= '0;
      r_perf_sb     <= '0;
    end else begin
      if (fwd_stall && !w_stall_sb && (r_perf_hazard != '1)) begin
        r_perf_hazard <= r_perf_hazard + 32'd1;
      end
      if (fwd_stall && w_stall_sb && (r_perf_sb != '1)) begin
        r_perf_sb <= r_perf_sb + 32'd1;
      end
    end
  end

  assign perf_hazard_cnt = r_perf_hazard;
  assign perf_sb_cnt     = r_perf_sb;
`else
  assign perf_hazard_cnt = '0;
  assign perf_sb_cnt     = '0;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n) r_count <= LL_MAX);
  a_done_busy:   assert property (@(posedge clk) disable iff (!reset_n)
                                  !(ll_done_valid && !r_busy[ll_done_reg]));

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - randomized self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

  localparam int NR = 2;
  localparam int NS = 3;
  localparam int NL = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        de_valid;
  logic [9:0]  de_rs;
  logic [4:0]  de_rd;
  logic        de_rd_en;
  logic [2:0]  st_fwd_valid;
  logic [2:0]  st_fwd_stall;
  logic [14:0] st_wb_reg;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_reg;
  logic        ll_issue_ready;
  logic        ll_done_valid;
  logic [4:0]  ll_done_reg;
  logic        flush;
  logic [7:0]  fwd_sel;
  logic        fwd_stall;
  logic [31:0] sb_busy;
  logic [31:0] perf_hazard_cnt;
  logic [31:0] perf_sb_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // reference state: set of outstanding long-latency destinations
  logic [31:0] m_busy;
  logic        m_ready;
  logic        m_inc_h, m_inc_s;
  int          m_ph, m_ps;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_RS(NR), .NUM_STAGES(NS), .NUM_LL(NL), .REG_W(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .de_valid        (de_valid),
    .de_rs           (de_rs),
    .de_rd           (de_rd),
    .de_rd_en        (de_rd_en),
    .st_fwd_valid    (st_fwd_valid),
    .st_fwd_stall    (st_fwd_stall),
    .st_wb_reg       (st_wb_reg),
    .ll_issue_valid  (ll_issue_valid),
    .ll_issue_reg    (ll_issue_reg),
    .ll_issue_ready  (ll_issue_ready),
    .ll_done_valid   (ll_done_valid),
    .ll_done_reg     (ll_done_reg),
    .flush           (flush),
    .fwd_sel         (fwd_sel),
    .fwd_stall       (fwd_stall),
    .sb_busy         (sb_busy),
    .perf_hazard_cnt (perf_hazard_cnt),
    .perf_sb_cnt     (perf_sb_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset_n        = 1'b1;
    de_valid       = 1'b0;
    de_rs          = '0;
    de_rd          = '0;
    de_rd_en       = 1'b0;
    st_fwd_valid   = '0;
    st_fwd_stall   = '0;
    st_wb_reg      = '0;
    ll_issue_valid = 1'b0;
    ll_issue_reg   = '0;
    ll_done_valid  = 1'b0;
    ll_done_reg    = '0;
    flush          = 1'b0;
  endtask

  // derive expected outputs straight from the resolution rules and compare
  task automatic settle();
    logic [7:0] e_sel;
    logic       any_stage, any_sb, waw, e_stall;
    int         cnt;
    #1;
    e_sel = '0; any_stage = 0; any_sb = 0;
    for (int i = 0; i < NR; i++) begin
      logic [4:0] r;
      logic       found;
      r = de_rs[i*5 +: 5];
      found = 0;
      if (r != 0) begin
        for (int s = 0; s < NS; s++) begin
          if (!found && st_fwd_valid[s] && st_wb_reg[s*5 +: 5] == r) begin
            found = 1;
            e_sel[i*4 + s] = 1'b1;
            if (st_fwd_stall[s]) any_stage = 1;
          end
        end
        if (!found) begin
          if (ll_done_valid && ll_done_reg == r) e_sel[i*4 + 3] = 1'b1;
          else if (m_busy[r]) any_sb = 1;
        end
      end
    end
    waw = de_valid && de_rd_en && de_rd != 0 && m_busy[de_rd] &&
          !(ll_done_valid && ll_done_reg == de_rd);
    e_stall = de_valid && (any_stage || any_sb || waw);
    if (!de_valid) e_sel = '0;
    cnt = $countones(m_busy);
    m_ready = (cnt < NL || ll_done_valid) &&
              (!m_busy[ll_issue_reg] || (ll_done_valid && ll_done_reg == ll_issue_reg));
    m_inc_h = e_stall && !(any_sb || waw);
    m_inc_s = e_stall && (any_sb || waw);
    check_eq("fwd_sel", 64'(fwd_sel), 64'(e_sel));
    check_eq("fwd_stall", 64'(fwd_stall), 64'(e_stall));
    check_eq("ll_issue_ready", 64'(ll_issue_ready), 64'(m_ready));
    check_eq("sb_busy", 64'(sb_busy), 64'(m_busy));
`ifdef FWD_SCOREBOARD_PERF_EN
    check_eq("perf_hazard", 64'(perf_hazard_cnt), 64'(m_ph));
    check_eq("perf_sb", 64'(perf_sb_cnt), 64'(m_ps));
`else
    check_eq("perf_hazard", 64'(perf_hazard_cnt), 64'd0);
    check_eq("perf_sb", 64'(perf_sb_cnt), 64'd0);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset_n || flush) begin
      m_busy = '0;
    end else begin
      if (ll_done_valid) m_busy[ll_done_reg] = 1'b0;
      if (ll_issue_valid && m_ready && ll_issue_reg != 0) m_busy[ll_issue_reg] = 1'b1;
    end
    if (!reset_n) begin
      m_ph = 0; m_ps = 0;
    end else begin
      m_ph += int'(m_inc_h);
      m_ps += int'(m_inc_s);
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); ll_issue_valid = 1; ll_issue_reg = r; settle(); advance();
  endtask

  task automatic done(input logic [4:0] r);
    idle(); ll_done_valid = 1; ll_done_reg = r; settle(); advance();
  endtask

  initial begin
    int q[$];
    m_busy = '0; m_ready = 1; m_inc_h = 0; m_inc_s = 0; m_ph = 0; m_ps = 0;
    idle();
    reset_n = 0;
    advance();
    advance();

    // reset then idle
    idle(); settle();
    check_eq("rst_busy", 64'(sb_busy), 64'd0);
    check_eq("rst_ready", 64'(ll_issue_ready), 64'd1);
    check_eq("rst_stall", 64'(fwd_stall), 64'd0);
    advance();

    // youngest of two matching stages selected on both ports
    idle(); de_valid = 1; de_rs = {5'd5, 5'd5};
    st_fwd_valid = 3'b101; st_wb_reg = {5'd5, 5'd0, 5'd5};
    settle();
    check_eq("two_stage_sel", 64'(fwd_sel), 64'h11);
    check_eq("two_stage_nostall", 64'(fwd_stall), 64'd0);
    st_fwd_stall = 3'b001; settle();
    check_eq("stage0_stall", 64'(fwd_stall), 64'd1);
    advance();

    // long-latency read-after-write, then completion bypass
    issue(5'd7);
    idle(); de_valid = 1; de_rs = {5'd0, 5'd7}; settle();
    check_eq("ll_raw_stall", 64'(fwd_stall), 64'd1);
    check_eq("ll_raw_sel", 64'(fwd_sel), 64'd0);
    ll_done_valid = 1; ll_done_reg = 5'd7; settle();
    check_eq("ll_bypass_sel", 64'(fwd_sel), 64'h08);
    check_eq("ll_bypass_stall", 64'(fwd_stall), 64'd0);
    advance();
    idle(); settle();
    check_eq("ll_cleared", 64'(sb_busy[7]), 64'd0);
    advance();

    // capacity full, freed by same-cycle completion
    issue(5'd3);
    issue(5'd4);
    idle(); ll_issue_valid = 1; ll_issue_reg = 5'd9; settle();
    check_eq("full_ready", 64'(ll_issue_ready), 64'd0);
    ll_done_valid = 1; ll_done_reg = 5'd3; settle();
    check_eq("free_ready", 64'(ll_issue_ready), 64'd1);
    advance();
    idle(); ll_issue_valid = 1; ll_issue_reg = 5'd10; settle();
    check_eq("swap_busy", 64'(sb_busy), 64'h0000_0210);
    check_eq("still_full", 64'(ll_issue_ready), 64'd0);
    advance();
    done(5'd4);
    done(5'd9);

    // write-after-write protection
    issue(5'd6);
    idle(); de_valid = 1; de_rd = 5'd6; de_rd_en = 1; settle();
    check_eq("waw_stall", 64'(fwd_stall), 64'd1);
    ll_issue_valid = 1; ll_issue_reg = 5'd6; settle();
    check_eq("waw_reissue_ready", 64'(ll_issue_ready), 64'd0);
    advance();
    done(5'd6);

    // flush with a same-cycle issue, then reset mid-operation
    issue(5'd3);
    issue(5'd4);
    idle(); flush = 1; ll_issue_valid = 1; ll_issue_reg = 5'd8; settle(); advance();
    idle(); settle();
    check_eq("flush_busy", 64'(sb_busy), 64'd0);
    check_eq("flush_ready", 64'(ll_issue_ready), 64'd1);
    advance();
    issue(5'd3);
    issue(5'd4);
    idle(); reset_n = 0; ll_issue_valid = 1; ll_issue_reg = 5'd8; settle(); advance();
    idle(); settle();
    check_eq("midrst_busy", 64'(sb_busy), 64'd0);
    check_eq("midrst_ready", 64'(ll_issue_ready), 64'd1);
    advance();

    // randomized traffic on a small register window to force collisions
    for (int c = 0; c < 2000; c++) begin
      idle();
      de_valid       = ($urandom % 4) != 0;
      de_rs          = {5'($urandom % 10), 5'($urandom % 10)};
      de_rd          = 5'($urandom % 10);
      de_rd_en       = 1'($urandom);
      st_fwd_valid   = 3'($urandom);
      st_fwd_stall   = 3'($urandom) & 3'($urandom);
      st_wb_reg      = {5'($urandom % 10), 5'($urandom % 10), 5'($urandom % 10)};
      ll_issue_valid = 1'($urandom);
      ll_issue_reg   = 5'($urandom % 10);
      q.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
      if (q.size() > 0 && ($urandom % 3) == 0) begin
        ll_done_valid = 1;
        ll_done_reg   = 5'(q[$urandom % q.size()]);
      end
      flush   = ($urandom % 50) == 0;
      reset_n = ($urandom % 100) != 0;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
